la_bec_ctrl: RTL and testbench
==============================

// Module: la_bec_ctrl
// PURPOSE
// - Logic-analyzer (LA) front end of the user project. Sits between the management-core LA bus and the BEC point-arithmetic core.
// - Receives operand words from firmware over a 4-phase req/ack handshake and packs them into wide operands.
// - Starts the core, then returns the result words to firmware the same way.
// - Publishes test progress codes on mprj_io[31:16] and the current test id on mprj_io[15:8] for the GPIO monitor.
// PARAMETERS
// - DATA_W    163    operand/result width in bits
// - WORD_W    32     LA transfer word width
// - N_OPS     2      operands per test
// - TIMEOUT   65535  max cycles in PROC before the run is declared failed
// - HOLD_CYC  16     min cycles each verdict code (AB43/AB44) is held on status
// - Derived (localparam): N_WORDS = (DATA_W+WORD_W-1)/WORD_W (6 at defaults)
// PORTS
// - wb_clk_i     in   1                single clock
// - wb_rst_i     in   1                reset, synchronous, active-high
// - la_wdata     in   WORD_W           operand word from firmware
// - la_id        in   8                test id; sampled on the first req of a test
// - la_req       in   1                firmware request (4-phase)
// - la_last      in   1                set by firmware with the first req of the final test
// - la_rdata     out  WORD_W           result word to firmware
// - la_ack       out  1                block acknowledge (4-phase)
// - core_start   out  1                1-cycle start pulse to the BEC core
// - core_op      out  N_OPS*DATA_W     packed operands, op0 in the LSBs
// - core_done    in   1                1-cycle completion pulse from the core
// - core_result  in   DATA_W           result; valid in the cycle core_done is high
// - io_out       out  24               {status[15:0], id[7:0]}, drives mprj_io[31:8]
// - io_oeb       out  24               all 0 (outputs enabled) after reset
// BEHAVIOUR
// - Reset values: la_ack=0, la_rdata=0, core_start=0, core_op=0, status=16'h0000, id=0, io_oeb=0, state=IDLE.
//   Reset mid-transfer aborts the test; no partial result is ever returned.
// - Handshake, all signals on wb_clk_i with no synchronisers:
//   - Rising edge of la_req is detected from a registered copy; the block acts the cycle after that edge.
//   - On acting, the block sets la_ack=1.
//   - When la_req is seen low, the block clears la_ack.
//   - A new la_req rise while la_ack=1 is ignored.
// - IDLE (status 0000; ABFF after the last test):
//   - Next la_req rise: capture la_id and la_last, set status AB40, go to READ.
//   - That first req also carries word 0 of op0.
// - READ (AB41 from the second word on):
//   - Each req stores la_wdata into word k of operand j. Order: k=0..N_WORDS-1, then j=0..N_OPS-1.
//   - The top word is truncated to DATA_W bits; excess MSBs are dropped.
//   - After the last word's ack falls: set status AB42, pulse core_start, go to PROC.
// - PROC (AB42): 16-bit cycle counter.
//   - core_done arrives: latch core_result, fail=0.
//   - Counter reaches TIMEOUT: latch result=0, fail=1.
//   - If core_done and timeout land in the same cycle, core_done wins.
//   - Either exit goes to WRITE.
// - WRITE (AB51): each la_req rise is answered with la_rdata = result word k, LSB word first.
//   - The top word is zero-extended.
//   - la_rdata is held stable until the next transfer.
// - After the ack of word N_WORDS-1 falls:
//   - Set status AB43 (fail=0) or AB44 (fail=1) and hold it HOLD_CYC cycles.
//   - Then return to IDLE, or to DONE if la_last was captured.
// - DONE (ABFF): terminal; only wb_rst_i leaves it.
// - Spurious core_done outside PROC is ignored.
// - Every status code is held for at least 1 cycle.
// STRUCTURE
// - Package bec_la_pkg holds:
//   - status constants ST_START=AB40, ST_READ=AB41, ST_PROC=AB42, ST_WRITE=AB51, ST_OK=AB43, ST_FAIL=AB44, ST_ALL=ABFF
//   - state enum IDLE/READ/PROC/WRITE/VERDICT/DONE
// - One sub-module, la_handshake: req edge detect, ack generation, 1-cycle xfer strobe.
// - Word/operand counters and the FSM stay in the top module.
// TESTING
// - Reset: wb_rst_i high 3 cycles -> io_out=24'h0, la_ack=0, core_start=0.
// - Happy path:
//   - Stimulus: id=8'h01; 12 words 0x11110000+i; model core returns done after 50 cycles with result=op0^op1.
//   - Response: status sequence AB40, AB41, AB42, AB51, AB43.
//   - 6 read words match the XOR; top word has 29 upper bits zero; IDLE afterwards.
// - Timeout: core never asserts done.
//   - Exactly TIMEOUT cycles in AB42, then AB51.
//   - All 6 read words = 0, then AB44 held >=16 cycles.
// - Last test: id=8'h07 with la_last=1 on the first req -> after AB43 the status goes to ABFF and stays there.
// - Protocol robustness:
//   - Hold la_req high across 5 cycles -> a single word is captured.
//   - core_done pulsed during READ -> ignored; FSM stays in AB41.
//   - core_done in the same cycle as timeout -> AB43.
// - Reset mid-WRITE after word 2: status=0000, la_ack=0.
//   - A new test id=8'h02 then completes with AB43.

Source files
------------

// File: rtl/bec_la_pkg.sv
// bec_la_pkg: status codes published on the GPIO monitor and the FSM state
// type shared by the LA front end of the BEC point-arithmetic core.
package bec_la_pkg;

   localparam logic [15:0] ST_IDLE  = 16'h0000;
   localparam logic [15:0] ST_START = 16'hAB40;
   localparam logic [15:0] ST_READ  = 16'hAB41;
   localparam logic [15:0] ST_PROC  = 16'hAB42;
   localparam logic [15:0] ST_WRITE = 16'hAB51;
   localparam logic [15:0] ST_OK    = 16'hAB43;
   localparam logic [15:0] ST_FAIL  = 16'hAB44;
   localparam logic [15:0] ST_ALL   = 16'hABFF;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      PROC,
      WRITE,
      VERDICT,
      DONE
   } state_t;

endpackage

// File: rtl/la_handshake.sv
// la_handshake: 4-phase req/ack responder for the LA bus. Detects the rising
// edge of req from a registered copy, raises ack on an accepted rise and drops
// it once req is seen low. o_xfer marks the single cycle in which a word is
// accepted; o_ack_fall marks the cycle in which ack is being released.
module la_handshake (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req,
   output logic o_ack,
   output logic o_xfer,
   output logic o_ack_fall
);

   logic r_req_q;
   logic r_ack;

   // A rise seen while ack is still high is ignored.
   assign o_xfer     = i_req & ~r_req_q & ~r_ack;
   assign o_ack_fall = r_ack & ~i_req;
   assign o_ack      = r_ack;

   // Registered copy of req for edge detection, and the ack flag.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_req_q <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_req_q <= i_req;
         if (o_xfer)
            r_ack <= 1'b1;
         else if (o_ack_fall)
            r_ack <= 1'b0;
      end
   end

endmodule

// File: rtl/la_bec_ctrl.sv
// la_bec_ctrl: LA front end of the BEC core. Collects N_OPS operands of
// DATA_W bits as WORD_W-bit words over the LA handshake, starts the core,
// returns the result word by word and reports progress on mprj_io[31:8].
module la_bec_ctrl
   import bec_la_pkg::*;
#(
   parameter int DATA_W   = 163,
   parameter int WORD_W   = 32,
   parameter int N_OPS    = 2,
   parameter int TIMEOUT  = 65535,
   parameter int HOLD_CYC = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [WORD_W-1:0]         la_wdata,
   input  logic [7:0]                la_id,
   input  logic                      la_req,
   input  logic                      la_last,
   output logic [WORD_W-1:0]         la_rdata,
   output logic                      la_ack,
   output logic                      core_start,
   output logic [N_OPS*DATA_W-1:0]   core_op,
   input  logic                      core_done,
   input  logic [DATA_W-1:0]         core_result,
   output logic [23:0]               io_out,
   output logic [23:0]               io_oeb
);

   localparam int N_WORDS = (DATA_W + WORD_W - 1) / WORD_W;
   // Width of the topmost (partial) word of an operand or result.
   localparam int TOP_W   = DATA_W - (N_WORDS - 1) * WORD_W;
   localparam int N_TOT   = N_OPS * N_WORDS;
   localparam int IDX_W   = $clog2(N_TOT + 1);

   localparam logic [IDX_W-1:0] RD_END   = IDX_W'(N_TOT);
   localparam logic [IDX_W-1:0] WR_END   = IDX_W'(N_WORDS);
   localparam logic [15:0]      TMO_CNT  = 16'(TIMEOUT);
   localparam logic [15:0]      HOLD_CNT = 16'(HOLD_CYC);

   logic                    w_xfer;
   logic                    w_ack_fall;
   logic                    w_wr_en;
   logic [IDX_W-1:0]        w_wr_idx;
   state_t                  w_state_nxt;
   logic [15:0]             w_status_nxt;
   logic                    w_start_nxt;

   state_t                  r_state;
   logic [15:0]             r_status;
   logic                    r_start;
   logic [7:0]              r_id;
   logic                    r_last;
   logic [IDX_W-1:0]        r_widx;
   logic [15:0]             r_cnt;
   logic [15:0]             r_hold;
   logic                    r_fail;
   logic [DATA_W-1:0]       r_result;
   logic [WORD_W-1:0]       r_rdata;
   logic [N_OPS*DATA_W-1:0] r_op;

   la_handshake u_hs (
      .i_clk      (wb_clk_i),
      .i_rst      (wb_rst_i),
      .i_req      (la_req),
      .o_ack      (la_ack),
      .o_xfer     (w_xfer),
      .o_ack_fall (w_ack_fall)
   );

   assign core_op    = r_op;
   assign core_start = r_start;
   assign la_rdata   = r_rdata;
   assign io_out     = {r_status, r_id};
   assign io_oeb     = '0;

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic. Operand phase ends on the last word's ack release,
   // result phase likewise; core_done outranks the timeout.
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_state_nxt = READ;
         READ:    if (w_ack_fall && r_widx == RD_END) w_state_nxt = PROC;
         PROC:    if (core_done || r_cnt == TMO_CNT) w_state_nxt = WRITE;
         WRITE:   if (w_ack_fall && r_widx == WR_END) w_state_nxt = VERDICT;
         VERDICT: if (r_hold == HOLD_CNT) w_state_nxt = r_last ? DONE : IDLE;
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: next status code and the core start pulse, decoded from
   // the state transition being taken.
   always_comb begin
      w_status_nxt = r_status;
      w_start_nxt  = 1'b0;
      if (w_state_nxt != r_state) begin
         case (w_state_nxt)
            READ:    w_status_nxt = ST_START;
            PROC: begin
               w_status_nxt = ST_PROC;
               w_start_nxt  = 1'b1;
            end
            WRITE:   w_status_nxt = ST_WRITE;
            VERDICT: w_status_nxt = r_fail ? ST_FAIL : ST_OK;
            DONE:    w_status_nxt = ST_ALL;
            default: w_status_nxt = ST_IDLE;
         endcase
      end else if (r_state == READ && w_xfer) begin
         w_status_nxt = ST_READ;
      end
   end

   // Operand word write enable; the first req of a test carries word 0.
   always_comb begin
      w_wr_en  = w_xfer && (r_state == IDLE || (r_state == READ && r_widx != RD_END));
      w_wr_idx = (r_state == IDLE) ? '0 : r_widx;
   end

   // Operand store: word k of operand j, top word truncated to DATA_W.
   // NOTE: this is a register bank, not a RAM, so it is reset; that keeps
   // core_op at zero out of reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_op <= '0;
      end else if (w_wr_en) begin
         for (int j = 0; j < N_OPS; j++) begin
            for (int k = 0; k < N_WORDS - 1; k++) begin
               if (w_wr_idx == IDX_W'(j * N_WORDS + k))
                  r_op[j*DATA_W + k*WORD_W +: WORD_W] <= la_wdata;
            end
            if (w_wr_idx == IDX_W'(j * N_WORDS + N_WORDS - 1))
               r_op[j*DATA_W + DATA_W - TOP_W +: TOP_W] <= la_wdata[TOP_W-1:0];
         end
      end
   end

   // Test bookkeeping: id/last capture, word index, PROC timer, verdict hold
   // timer, result capture and the readback word.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_status <= ST_IDLE;
         r_start  <= 1'b0;
         r_id     <= '0;
         r_last   <= 1'b0;
         r_widx   <= '0;
         r_cnt    <= '0;
         r_hold   <= '0;
         r_fail   <= 1'b0;
         r_result <= '0;
         r_rdata  <= '0;
      end else begin
         r_status <= w_status_nxt;
         r_start  <= w_start_nxt;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_id   <= la_id;
                  r_last <= la_last;
                  r_widx <= IDX_W'(1);
               end
            end
            READ: begin
               // PROC timer starts at 1 so it equals TIMEOUT in its last cycle.
               r_cnt <= 16'd1;
               if (w_wr_en)
                  r_widx <= r_widx + IDX_W'(1);
            end
            PROC: begin
               r_widx <= '0;
               if (core_done) begin
                  r_result <= core_result;
                  r_fail   <= 1'b0;
               end else if (r_cnt == TMO_CNT) begin
                  r_result <= '0;
                  r_fail   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            WRITE: begin
               r_hold <= 16'd1;
               if (w_xfer && r_widx != WR_END) begin
                  r_widx <= r_widx + IDX_W'(1);
                  for (int k = 0; k < N_WORDS - 1; k++) begin
                     if (r_widx == IDX_W'(k))
                        r_rdata <= r_result[k*WORD_W +: WORD_W];
                  end
                  if (r_widx == IDX_W'(N_WORDS - 1))
                     r_rdata <= WORD_W'(r_result[DATA_W-1 -: TOP_W]);
               end
            end
            VERDICT: r_hold <= r_hold + 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_la_bec_ctrl.sv
// tb_la_bec_ctrl: directed bench for la_bec_ctrl with a behavioural XOR core.
module tb_la_bec_ctrl;
   import bec_la_pkg::*;

   localparam int DATA_W   = 163;
   localparam int WORD_W   = 32;
   localparam int N_OPS    = 2;
   localparam int TIMEOUT  = 200;
   localparam int HOLD_CYC = 16;
   localparam int N_WORDS  = 6;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [WORD_W-1:0]       la_wdata = '0;
   logic [7:0]              la_id = '0;
   logic                    la_req = 1'b0;
   logic                    la_last = 1'b0;
   logic [WORD_W-1:0]       la_rdata;
   logic                    la_ack;
   logic                    core_start;
   logic [N_OPS*DATA_W-1:0] core_op;
   logic                    core_done;
   logic [DATA_W-1:0]       core_result = '0;
   logic [23:0]             io_out;
   logic [23:0]             io_oeb;

   logic m_done = 1'b0;
   logic s_done = 1'b0;
   int   core_delay = -1;
   int   n_vec = 0;
   int   n_fail = 0;

   logic [31:0] tx_words [12];
   logic [31:0] rd_buf [N_WORDS];
   logic [31:0] rd;

   assign core_done = m_done | s_done;

   always #5 clk = ~clk;

   la_bec_ctrl #(
      .DATA_W(DATA_W), .WORD_W(WORD_W), .N_OPS(N_OPS),
      .TIMEOUT(TIMEOUT), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .la_wdata(la_wdata), .la_id(la_id), .la_req(la_req), .la_last(la_last),
      .la_rdata(la_rdata), .la_ack(la_ack),
      .core_start(core_start), .core_op(core_op),
      .core_done(core_done), .core_result(core_result),
      .io_out(io_out), .io_oeb(io_oeb)
   );

   // Behavioural core: answers op0^op1 core_delay cycles after start; -1 never answers.
   always begin
      @(negedge clk);
      if (core_start === 1'b1 && core_delay >= 0) begin
         repeat (core_delay) @(negedge clk);
         m_done      = 1'b1;
         core_result = core_op[DATA_W-1:0] ^ core_op[2*DATA_W-1:DATA_W];
         @(negedge clk);
         m_done = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [DATA_W-1:0] pack_op(input int j);
      logic [N_WORDS*WORD_W-1:0] t;
      for (int k = 0; k < N_WORDS; k++) t[k*WORD_W +: WORD_W] = tx_words[j*N_WORDS + k];
      return t[DATA_W-1:0];
   endfunction

   function automatic logic [31:0] exp_word(input int k, input logic fail);
      logic [N_WORDS*WORD_W-1:0] p;
      p = '0;
      if (!fail) p[DATA_W-1:0] = pack_op(0) ^ pack_op(1);
      return p[k*WORD_W +: WORD_W];
   endfunction

   task automatic wait_ack(input logic lvl, input string tag);
      int n;
      n = 0;
      while (la_ack !== lvl && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(la_ack), 64'(lvl));
   endtask

   task automatic xfer(input logic [31:0] wd, input logic [7:0] id, input logic last,
                       output logic [31:0] rdo);
      la_wdata = wd;
      la_id    = id;
      la_last  = last;
      la_req   = 1'b1;
      wait_ack(1'b1, "ack_rise");
      rdo    = la_rdata;
      la_req = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   // Called in the first PROC cycle: start pulse, status and operand packing.
   task automatic check_start();
      logic [N_WORDS*WORD_W-1:0] ob;
      logic [N_WORDS*WORD_W-1:0] ex;
      check("core_start_hi", 64'(core_start), 64'd1);
      check("st_proc", 64'(io_out[23:8]), 64'(ST_PROC));
      for (int j = 0; j < N_OPS; j++) begin
         ob = '0;
         ex = '0;
         ob[DATA_W-1:0] = core_op[j*DATA_W +: DATA_W];
         ex[DATA_W-1:0] = pack_op(j);
         for (int k = 0; k < N_WORDS; k++)
            check($sformatf("core_op%0d_w%0d", j, k), 64'(ob[k*WORD_W +: WORD_W]),
                  64'(ex[k*WORD_W +: WORD_W]));
      end
      tick(1);
      check("core_start_lo", 64'(core_start), 64'd0);
   endtask

   task automatic send_ops(input logic [7:0] id, input logic last, input logic [31:0] base);
      for (int i = 0; i < 12; i++) begin
         tx_words[i] = base + 32'(i);
         xfer(tx_words[i], id, last, rd);
         if (i == 0) begin
            check("st_start", 64'(io_out[23:8]), 64'(ST_START));
            check("id", 64'(io_out[7:0]), 64'(id));
         end
         if (i == 1) check("st_read", 64'(io_out[23:8]), 64'(ST_READ));
      end
      check_start();
   endtask

   task automatic proc_phase(input int exp_cyc);
      int n;
      n = 1;
      while (io_out[23:8] == ST_PROC && n < TIMEOUT + 20) begin
         n++;
         @(negedge clk);
      end
      check("proc_cycles", 64'(n), 64'(exp_cyc));
      check("st_write", 64'(io_out[23:8]), 64'(ST_WRITE));
   endtask

   task automatic read_words(input int cnt, input logic fail);
      for (int k = 0; k < cnt; k++) begin
         xfer(32'h0, 8'h0, 1'b0, rd_buf[k]);
         check($sformatf("rd_w%0d", k), 64'(rd_buf[k]), 64'(exp_word(k, fail)));
      end
   endtask

   task automatic verdict(input logic [15:0] code, input logic [15:0] after);
      int n;
      check("st_verdict", 64'(io_out[23:8]), 64'(code));
      n = 0;
      while (io_out[23:8] == code && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("verdict_hold", 64'(n >= HOLD_CYC), 64'd1);
      check("st_after", 64'(io_out[23:8]), 64'(after));
   endtask

   initial begin
      // Reset held 3 cycles.
      tick(3);
      check("rst_io_out", 64'(io_out), 64'h0);
      check("rst_ack", 64'(la_ack), 64'd0);
      check("rst_start", 64'(core_start), 64'd0);
      check("rst_oeb", 64'(io_oeb), 64'h0);
      check("rst_core_op", 64'(|core_op), 64'd0);
      rst = 1'b0;
      tick(1);

      // Happy path: id 01, core answers in cycle 50 of PROC.
      core_delay = 50;
      send_ops(8'h01, 1'b0, 32'h11110000);
      proc_phase(51);
      read_words(N_WORDS, 1'b0);
      check("hp_w0", 64'(rd_buf[0]), 64'h6);
      check("hp_w1", 64'(rd_buf[1]), 64'h6);
      check("hp_w2", 64'(rd_buf[2]), 64'hA);
      check("hp_w3", 64'(rd_buf[3]), 64'hA);
      check("hp_w4", 64'(rd_buf[4]), 64'hE);
      check("hp_w5", 64'(rd_buf[5]), 64'h6);
      check("hp_top_zero", 64'(rd_buf[5][31:3]), 64'h0);
      verdict(ST_OK, ST_IDLE);

      // Timeout: core never answers.
      core_delay = -1;
      send_ops(8'h10, 1'b0, 32'hA5A50000);
      proc_phase(TIMEOUT);
      read_words(N_WORDS, 1'b1);
      verdict(ST_FAIL, ST_IDLE);

      // Robustness: held req, spurious done in READ, done coincident with timeout.
      core_delay = TIMEOUT - 1;
      tx_words[0] = 32'h33330000;
      xfer(tx_words[0], 8'h03, 1'b0, rd);
      tx_words[1] = 32'h33330001;
      la_wdata = tx_words[1];
      la_req   = 1'b1;
      wait_ack(1'b1, "hold_ack_rise");
      la_wdata = 32'hDEAD0001;
      tick(5);
      check("hold_ack_stays", 64'(la_ack), 64'd1);
      la_req = 1'b0;
      wait_ack(1'b0, "hold_ack_fall");
      check("hold_st_read", 64'(io_out[23:8]), 64'(ST_READ));
      tx_words[2] = 32'h33330002;
      xfer(tx_words[2], 8'h03, 1'b0, rd);
      s_done = 1'b1;
      tick(1);
      s_done = 1'b0;
      tick(1);
      check("spurious_done", 64'(io_out[23:8]), 64'(ST_READ));
      for (int i = 3; i < 12; i++) begin
         tx_words[i] = 32'h33330000 + 32'(i);
         xfer(tx_words[i], 8'h03, 1'b0, rd);
      end
      check_start();
      proc_phase(TIMEOUT);
      read_words(N_WORDS, 1'b0);
      verdict(ST_OK, ST_IDLE);

      // Reset in the middle of WRITE, then a fresh test completes.
      core_delay = 5;
      send_ops(8'h05, 1'b0, 32'h55550000);
      proc_phase(6);
      read_words(3, 1'b0);
      rst = 1'b1;
      tick(2);
      check("mid_rst_io_out", 64'(io_out), 64'h0);
      check("mid_rst_ack", 64'(la_ack), 64'd0);
      check("mid_rst_rdata", 64'(la_rdata), 64'h0);
      rst = 1'b0;
      tick(1);
      send_ops(8'h02, 1'b0, 32'h22220000);
      proc_phase(6);
      read_words(N_WORDS, 1'b0);
      verdict(ST_OK, ST_IDLE);

      // Last test: terminal ABFF afterwards.
      core_delay = 10;
      send_ops(8'h07, 1'b1, 32'h77770000);
      proc_phase(11);
      read_words(N_WORDS, 1'b0);
      verdict(ST_OK, ST_ALL);
      tick(30);
      check("done_stays", 64'(io_out[23:8]), 64'(ST_ALL));
      xfer(32'h12345678, 8'h09, 1'b0, rd);
      tick(3);
      check("done_ignores_req", 64'(io_out), 64'({ST_ALL, 8'h07}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
